// File: rtl/bitcoin_pkg.sv
// Shared types and defaults for the nonce search datapath.
package bitcoin_pkg;

   localparam int unsigned NUM_NONCES_DEF = 16;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned ADDR_W         = 16;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StWrNonce,
      StWrHash
   } state_e;

endpackage

// File: rtl/nonce_min_select_hash_min_tracker.sv
// Running minimum of a hash stream: clear, unconditional first load, then strict-less update.
module hash_min_tracker
   import bitcoin_pkg::*;
#(
   parameter int unsigned IDX_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load_first,
   input  logic              update,
   input  logic [WORD_W-1:0] hash_in,
   input  logic [IDX_W-1:0]  idx_in,
   output logic [WORD_W-1:0] best_hash,
   output logic [IDX_W-1:0]  best_idx
);

   logic [WORD_W-1:0] best_hash_q;
   logic [IDX_W-1:0]  best_idx_q;

   // Strict less-than keeps the earliest index on ties.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best_hash_q <= '0;
         best_idx_q  <= '0;
      end else if (clear) begin
         best_hash_q <= '0;
         best_idx_q  <= '0;
      end else if (load_first || (update && (hash_in < best_hash_q))) begin
         best_hash_q <= hash_in;
         best_idx_q  <= idx_in;
      end
   end

   assign best_hash = best_hash_q;
   assign best_idx  = best_idx_q;

endmodule

// File: rtl/nonce_min_select.sv
// Scans NUM_NONCES H0 words in shared memory, keeps the smallest and writes {nonce, hash} back.
// Optional TARGET_CHECK_EN: found compares the winning hash against the target.
module nonce_min_select
   import bitcoin_pkg::*;
#(
   parameter int unsigned NUM_NONCES = NUM_NONCES_DEF,
   parameter int unsigned NONCE_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  hash_addr,
   input  logic [ADDR_W-1:0]  result_addr,
   input  logic [NONCE_W-1:0] nonce_base,
   input  logic [WORD_W-1:0]  target,
   output logic               mem_clk,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WORD_W-1:0]  mem_write_data,
   input  logic [WORD_W-1:0]  mem_read_data,
   output logic               done,
   output logic               found,
   output logic [NONCE_W-1:0] best_nonce,
   output logic [WORD_W-1:0]  best_hash
);

   localparam int unsigned   KW     = $clog2(NUM_NONCES + 1);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_NONCES);

   state_e             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic               done_q, done_d;
   logic               found_q, found_d;
   logic               found_calc;
   logic               accept;
   logic [ADDR_W-1:0]  hash_addr_q, result_addr_q;
   logic [NONCE_W-1:0] nonce_base_q;
   logic               trk_clear, trk_first, trk_update;
   logic [KW-1:0]      best_idx;

   assign mem_clk = clk;
   // done_q lags the IDLE return by a cycle, so a start coinciding with it is dropped.
   assign accept  = start && (state_q == StIdle) && done_q;

   hash_min_tracker #(
      .IDX_W (KW)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .clear      (trk_clear),
      .load_first (trk_first),
      .update     (trk_update),
      .hash_in    (mem_read_data),
      .idx_in     (k_q - KW'(1)),
      .best_hash  (best_hash),
      .best_idx   (best_idx)
   );

   assign best_nonce = nonce_base_q + NONCE_W'(best_idx);

`ifdef TARGET_CHECK_EN
   logic [WORD_W-1:0] target_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target_q <= '0;
      end else if (accept) begin
         target_q <= target;
      end
   end

   assign found_calc = best_hash < target_q;
`else
   logic unused_target;

   assign unused_target = ^target;
   assign found_calc    = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         k_q           <= '0;
         done_q        <= 1'b1;
         found_q       <= 1'b0;
         hash_addr_q   <= '0;
         result_addr_q <= '0;
         nonce_base_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         done_q  <= done_d;
         found_q <= found_d;
         if (accept) begin
            hash_addr_q   <= hash_addr;
            result_addr_q <= result_addr;
            nonce_base_q  <= nonce_base;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      done_d         = done_q;
      found_d        = found_q;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      trk_clear      = 1'b0;
      trk_first      = 1'b0;
      trk_update     = 1'b0;
      unique case (state_q)
         StIdle: begin
            done_d = 1'b1;
            if (accept) begin
               state_d   = StScan;
               k_d       = '0;
               done_d    = 1'b0;
               found_d   = 1'b0;
               trk_clear = 1'b1;
            end
         end
         StScan: begin
            // Read data for index k-1 arrives while address k is presented.
            if (k_q != K_LAST) begin
               mem_addr = hash_addr_q + ADDR_W'(k_q);
            end
            if (k_q != '0) begin
               trk_first  = (k_q == KW'(1));
               trk_update = (k_q != KW'(1));
            end
            if (k_q == K_LAST) begin
               state_d = StWrNonce;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         StWrNonce: begin
            mem_we         = 1'b1;
            mem_addr       = result_addr_q;
            mem_write_data = WORD_W'(best_nonce);
            state_d        = StWrHash;
         end
         StWrHash: begin
            mem_we         = 1'b1;
            mem_addr       = result_addr_q + ADDR_W'(1);
            mem_write_data = best_hash;
            found_d        = found_calc;
            state_d        = StIdle;
         end
      endcase
   end

   assign done  = done_q;
   assign found = found_q;

endmodule

// File: tb/tb_nonce_min_select.sv
// Directed bench for nonce_min_select with a behavioural word memory and write log.
module tb_nonce_min_select;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] hash_addr, result_addr;
   logic [31:0] nonce_base, target;
   logic        mem_clk, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data, mem_read_data;
   logic        done, found;
   logic [31:0] best_nonce, best_hash;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:65535];
   logic [15:0] wr_addr [$];
   logic [31:0] wr_data [$];

   always #5 clk = ~clk;

   nonce_min_select #(
      .NUM_NONCES (16),
      .NONCE_W    (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .hash_addr      (hash_addr),
      .result_addr    (result_addr),
      .nonce_base     (nonce_base),
      .target         (target),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .done           (done),
      .found          (found),
      .best_nonce     (best_nonce),
      .best_hash      (best_hash)
   );

   always @(posedge mem_clk) begin
      mem_read_data <= mem[mem_addr];
      if (mem_we) begin
         mem[mem_addr] <= mem_write_data;
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_write_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic run(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] nb,
                      input logic [31:0] tg, output int low);
      @(negedge clk);
      hash_addr   = ha;
      result_addr = ra;
      nonce_base  = nb;
      target      = tg;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      hash_addr   = 16'hdead;
      result_addr = 16'hbeef;
      nonce_base  = 32'h5a5a5a5a;
      target      = 32'h0;
      low = 0;
      while (!done && low < 100) begin
         low++;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] ra, input logic [31:0] en,
                               input logic [31:0] eh, input logic ef);
      logic [15:0] ra1;
      ra1 = ra + 16'd1;
      chk({tag, ".nonce"}, best_nonce, en);
      chk({tag, ".hash"}, best_hash, eh);
      chk({tag, ".found"}, {31'd0, found}, {31'd0, ef});
      chk({tag, ".nwr"}, wr_addr.size(), 32'd2);
      if (wr_addr.size() == 2) begin
         chk({tag, ".wa0"}, {16'd0, wr_addr[0]}, {16'd0, ra});
         chk({tag, ".wd0"}, wr_data[0], en);
         chk({tag, ".wa1"}, {16'd0, wr_addr[1]}, {16'd0, ra1});
         chk({tag, ".wd1"}, wr_data[1], eh);
      end
   endtask

   initial begin
      int low;
      logic exp_found;
      reset       = 1'b1;
      start       = 1'b0;
      hash_addr   = '0;
      result_addr = '0;
      nonce_base  = '0;
      target      = '0;
      for (int i = 0; i < 16; i++) begin
         mem[16'h0100 + i] = 32'd100 - i;
         mem[16'h0300 + i] = 32'hffffffff;
         mem[16'h0400 + i] = 32'd1000 + i;
         mem[16'h0500 + i] = 32'h2000 + i;
      end
      mem[16'h0403] = 32'd5;
      mem[16'h040a] = 32'd5;
      mem[16'h0507] = 32'h00001000;

      repeat (2) @(negedge clk);
      chk("rst.done", {31'd0, done}, 32'd1);
      chk("rst.we", {31'd0, mem_we}, 32'd0);
      chk("rst.addr", {16'd0, mem_addr}, 32'd0);
      chk("rst.wdata", mem_write_data, 32'd0);
      chk("rst.found", {31'd0, found}, 32'd0);
      chk("rst.nonce", best_nonce, 32'd0);
      chk("rst.hash", best_hash, 32'd0);
      reset = 1'b0;

      // Descending hashes: last index is the minimum.
      clear_log();
      run(16'h0100, 16'h0200, 32'd0, 32'h00001000, low);
      chk("t1.low", low, 32'd20);
      check_result("t1", 16'h0200, 32'd15, 32'd85, 1'b1);
      chk("t1.mem0", mem[16'h0200], 32'd15);
      chk("t1.mem1", mem[16'h0201], 32'd85);

      // All equal: lowest index wins.
      clear_log();
`ifdef TARGET_CHECK_EN
      exp_found = 1'b0;
`else
      exp_found = 1'b1;
`endif
      run(16'h0300, 16'h0210, 32'd0, 32'hffffffff, low);
      check_result("t2", 16'h0210, 32'd0, 32'hffffffff, exp_found);

      // Nonce wrap, plus a tie at index 10 that must lose to index 3.
      clear_log();
      run(16'h0400, 16'hffff, 32'hfffffffe, 32'h00000100, low);
      check_result("t3", 16'hffff, 32'h00000001, 32'd5, 1'b1);

      // Target boundary.
      clear_log();
      run(16'h0500, 16'h0220, 32'd100, 32'h00001001, low);
      check_result("t4a", 16'h0220, 32'd107, 32'h00001000, 1'b1);
      clear_log();
`ifdef TARGET_CHECK_EN
      exp_found = 1'b0;
`else
      exp_found = 1'b1;
`endif
      run(16'h0500, 16'h0220, 32'd100, 32'h00001000, low);
      check_result("t4b", 16'h0220, 32'd107, 32'h00001000, exp_found);

      // Reset mid-scan at k=5.
      clear_log();
      @(negedge clk);
      hash_addr   = 16'h0100;
      result_addr = 16'h0700;
      nonce_base  = 32'd0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5.busy", {31'd0, done}, 32'd0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t5.done", {31'd0, done}, 32'd1);
      chk("t5.we", {31'd0, mem_we}, 32'd0);
      chk("t5.found", {31'd0, found}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("t5.nwr", wr_addr.size(), 32'd0);
      run(16'h0100, 16'h0700, 32'd0, 32'h00001000, low);
      chk("t5r.low", low, 32'd20);
      check_result("t5r", 16'h0700, 32'd15, 32'd85, 1'b1);

      // Start during SCAN and on the IDLE-return cycle are both ignored.
      clear_log();
      @(negedge clk);
      hash_addr   = 16'h0100;
      result_addr = 16'h0600;
      nonce_base  = 32'd0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      hash_addr   = 16'h0300;
      result_addr = 16'h0230;
      nonce_base  = 32'd77;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("t6.lastlow", {31'd0, done}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t6.up", {31'd0, done}, 32'd1);
      repeat (3) @(negedge clk);
      chk("t6.stay", {31'd0, done}, 32'd1);
      check_result("t6", 16'h0600, 32'd15, 32'd85, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
